keypad_number_entry: RTL and testbench

//  Parametrised push-button decimal entry with per-key debounce, clear/backspace/enter and a

---
 rtl/keypad_number_entry_pkg.sv | 26 ++
 rtl/keypad_number_entry_if.sv | 24 ++
 rtl/keypad_number_entry_debounce.sv | 62 ++++++
 rtl/keypad_number_entry.sv | 167 ++++++++++++++++
 tb/tb_keypad_number_entry.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_number_entry_pkg.sv
// Shared types and constants for the keypad number entry block.
package keypad_pkg;

  localparam int DIGIT_W   = 4;
  localparam int NUM_KEYS  = 13;
  localparam int KEY_CLR   = 10;
  localparam int KEY_BKSP  = 11;
  localparam int KEY_ENTER = 12;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Lowest set bit of a digit-key vector, as a BCD digit.
  function automatic logic [DIGIT_W-1:0] first_digit(input logic [9:0] hits);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 9; i >= 0; i--) begin
      if (hits[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/keypad_number_entry_if.sv
// Result port of the keypad entry block.
// valid/ready: the producer raises value_valid with value stable and keeps both unchanged
// until an edge where value_valid & value_ready are both 1; that edge is the transfer.
interface keypad_number_entry_if #(
  parameter int VAL_W = 14
) ();

  logic [VAL_W-1:0] value;
  logic             value_valid;
  logic             value_ready;

  modport master (
    output value,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/keypad_number_entry_debounce.sv
// One push-button: two-flop synchroniser, stable-level filter and rising-edge press pulse.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  logic sync1;
  logic s;
  logic level;
  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign level = s;
    end else begin : g_filter
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          stable;

      // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          stable <= 1'b0;
        end else if (s == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          stable <= s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign level = stable;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/keypad_number_entry.sv
// Decimal keypad entry: debounced keys fill a BCD buffer; ENTER converts it to binary
// over NUM_DIGITS cycles and presents the result on a valid/ready port.
module keypad_number_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int VAL_W = $clog2(10 ** NUM_DIGITS),
  localparam int CNT_W = $clog2(NUM_DIGITS + 1),
  localparam int BUF_W = DIGIT_W * NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              pb,
  input  logic                    pb_clr,
  input  logic                    pb_bksp,
  input  logic                    pb_enter,
  output logic [BUF_W-1:0]        digits_bcd,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    err,
  keypad_number_entry_if.master   res,
  output state_t                  state
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(NUM_DIGITS - 1);
  localparam logic [VAL_W-1:0] TEN  = VAL_W'(10);

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] press;

  assign raw_keys = {pb_enter, pb_bksp, pb_clr, pb};

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_keys[k]),
        .press(press[k])
      );
    end
  endgenerate

  state_t             state_q, state_nx;
  logic [BUF_W-1:0]   buf_q, buf_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [CNT_W-1:0]   idx_q, idx_nx;
  logic [VAL_W-1:0]   acc_q, acc_nx;
  logic [VAL_W-1:0]   val_q, val_nx;
  logic               valid_q, valid_nx;
  logic               err_q, err_nx;

  logic [3:0]         n_hits;
  logic [DIGIT_W-1:0] hit_digit;
  logic [DIGIT_W-1:0] slot;
  logic [VAL_W-1:0]   acc_step;

  always_comb begin
    n_hits = '0;
    for (int i = 0; i < 10; i++) begin
      n_hits = n_hits + 4'(press[i]);
    end
    hit_digit = first_digit(press[9:0]);
  end

  assign slot     = buf_q[idx_q * DIGIT_W +: DIGIT_W];
  assign acc_step = acc_q * TEN + VAL_W'(slot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ENTRY;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    buf_nx   = buf_q;
    cnt_nx   = cnt_q;
    idx_nx   = idx_q;
    acc_nx   = acc_q;
    val_nx   = val_q;
    valid_nx = valid_q;
    err_nx   = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (press[KEY_CLR]) begin
          buf_nx = '0;
          cnt_nx = '0;
        end else if (press[KEY_ENTER]) begin
          if (cnt_q == '0) begin
            err_nx = 1'b1;
          end else begin
            acc_nx   = '0;
            idx_nx   = TOP;
            state_nx = ST_CONVERT;
          end
        end else if (press[KEY_BKSP]) begin
          if (cnt_q == '0) begin
            err_nx = 1'b1;
          end else begin
            buf_nx = buf_q >> DIGIT_W;
            cnt_nx = cnt_q - 1'b1;
          end
        end else if (n_hits > 4'd1) begin
          err_nx = 1'b1;
        end else if (n_hits == 4'd1) begin
          if (cnt_q == FULL) begin
            err_nx = 1'b1;
          end else begin
            buf_nx = (buf_q << DIGIT_W) | BUF_W'(hit_digit);
            cnt_nx = cnt_q + 1'b1;
          end
        end
      end
      ST_CONVERT: begin
        // Most significant slot first; empty upper slots are zero and add nothing.
        acc_nx = acc_step;
        if (idx_q == '0) begin
          val_nx   = acc_step;
          valid_nx = 1'b1;
          state_nx = ST_PRESENT;
        end else begin
          idx_nx = idx_q - 1'b1;
        end
      end
      ST_PRESENT: begin
        if (res.value_ready) begin
          valid_nx = 1'b0;
          buf_nx   = '0;
          cnt_nx   = '0;
          state_nx = ST_ENTRY;
        end
      end
      default: state_nx = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_nx;
      cnt_q   <= cnt_nx;
      idx_q   <= idx_nx;
      acc_q   <= acc_nx;
      val_q   <= val_nx;
      valid_q <= valid_nx;
      err_q   <= err_nx;
    end
  end

  assign digits_bcd      = buf_q;
  assign digit_count     = cnt_q;
  assign err             = err_q;
  assign res.value       = val_q;
  assign res.value_valid = valid_q;
  assign state           = state_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench: instance 0 without debounce, instance 1 with DEBOUNCE_CYCLES=4.
module tb_keypad_number_entry;
  import keypad_pkg::*;

  logic clk;
  logic rst_n;

  logic [9:0]  pb0, pb1;
  logic        clr0, bksp0, enter0;
  logic        clr1, bksp1, enter1;
  logic [15:0] digits0, digits1;
  logic [2:0]  count0, count1;
  logic        err0, err1;
  state_t      state0, state1;

  int checks;
  int errors;
  int err_cnt0;
  int err_cnt1;

  keypad_number_entry_if #(.VAL_W(14)) res0 ();
  keypad_number_entry_if #(.VAL_W(14)) res1 ();

  keypad_number_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pb(pb0), .pb_clr(clr0), .pb_bksp(bksp0), .pb_enter(enter0),
    .digits_bcd(digits0), .digit_count(count0), .err(err0), .res(res0), .state(state0)
  );

  keypad_number_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .pb(pb1), .pb_clr(clr1), .pb_bksp(bksp1), .pb_enter(enter1),
    .digits_bcd(digits1), .digit_count(count1), .err(err1), .res(res1), .state(state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err0) err_cnt0++;
    if (err1) err_cnt1++;
  end

  function automatic logic [12:0] kd(input int d);
    logic [12:0] one;
    one = 13'd1;
    return one << d;
  endfunction

  // driver: one clean press on instance 0; outputs settle on the 3rd edge
  task automatic press0(input logic [12:0] k);
    {enter0, bksp0, clr0, pb0} = k;
    @(posedge clk); #1;
    {enter0, bksp0, clr0, pb0} = 13'd0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic accept0();
    res0.value_ready = 1'b1;
    @(posedge clk); #1;
    res0.value_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (digits0 !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h expected 0000", digits0); end
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count0); end
    checks++; if (res0.value !== 14'd0 || res0.value_valid !== 1'b0) begin errors++; $display("FAIL reset_value: got %0d/%b expected 0/0", res0.value, res0.value_valid); end
    checks++; if (err0 !== 1'b0 || state0 !== ST_ENTRY) begin errors++; $display("FAIL reset_state: got err %b state %0d expected 0/0", err0, state0); end
    checks++; if (digits1 !== 16'h0 || count1 !== 3'd0) begin errors++; $display("FAIL reset_dut1: got %h/%0d expected 0000/0", digits1, count1); end
  endtask

  task automatic test_entry_convert();
    int e0;
    press0(kd(1)); press0(kd(2)); press0(kd(3)); press0(kd(4));
    checks++; if (digits0 !== 16'h1234) begin errors++; $display("FAIL entry_digits: got %h expected 1234", digits0); end
    checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL entry_count: got %0d expected 4", count0); end
    enter0 = 1'b1;
    @(posedge clk); #1;
    enter0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state0 !== ST_CONVERT) begin errors++; $display("FAIL enter_to_convert: got %0d expected %0d", state0, ST_CONVERT); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res0.value_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b expected 0", res0.value_valid); end
    @(posedge clk); #1;
    checks++; if (res0.value_valid !== 1'b1 || res0.value !== 14'd1234) begin errors++; $display("FAIL convert_1234: got %0d/%b expected 1234/1", res0.value, res0.value_valid); end
    e0 = err_cnt0;
    press0(kd(5)); press0(13'h1 << KEY_CLR); press0(13'h1 << KEY_BKSP);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (res0.value_valid !== 1'b1 || res0.value !== 14'd1234 || state0 !== ST_PRESENT) begin errors++; $display("FAIL present_hold: got %0d/%b st %0d expected 1234/1 st 2", res0.value, res0.value_valid, state0); end
    checks++; if (digits0 !== 16'h1234 || count0 !== 3'd4 || err_cnt0 !== e0) begin errors++; $display("FAIL present_drop_keys: got %h/%0d errs %0d expected 1234/4 errs %0d", digits0, count0, err_cnt0, e0); end
    accept0();
    checks++; if (res0.value_valid !== 1'b0 || count0 !== 3'd0 || digits0 !== 16'h0) begin errors++; $display("FAIL accept: got %b/%0d/%h expected 0/0/0000", res0.value_valid, count0, digits0); end
    checks++; if (res0.value !== 14'd1234 || state0 !== ST_ENTRY) begin errors++; $display("FAIL accept_keep_value: got %0d st %0d expected 1234 st 0", res0.value, state0); end
  endtask

  task automatic test_overflow();
    int e0;
    for (int i = 0; i < 4; i++) press0(kd(9));
    e0 = err_cnt0;
    press0(kd(5));
    checks++; if (err_cnt0 !== e0 + 1) begin errors++; $display("FAIL full_err: got %0d pulses expected %0d", err_cnt0, e0 + 1); end
    checks++; if (digits0 !== 16'h9999 || count0 !== 3'd4) begin errors++; $display("FAIL full_buffer: got %h/%0d expected 9999/4", digits0, count0); end
    press0(13'h1 << KEY_ENTER);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (res0.value !== 14'd9999 || res0.value_valid !== 1'b1) begin errors++; $display("FAIL convert_9999: got %0d/%b expected 9999/1", res0.value, res0.value_valid); end
    accept0();
  endtask

  task automatic test_backspace();
    int e0;
    press0(kd(7)); press0(kd(8)); press0(13'h1 << KEY_BKSP); press0(kd(3));
    checks++; if (digits0 !== 16'h0073 || count0 !== 3'd2) begin errors++; $display("FAIL bksp_edit: got %h/%0d expected 0073/2", digits0, count0); end
    e0 = err_cnt0;
    press0(13'h1 << KEY_BKSP); press0(13'h1 << KEY_BKSP);
    checks++; if (err_cnt0 !== e0 || count0 !== 3'd0 || digits0 !== 16'h0) begin errors++; $display("FAIL bksp_to_empty: got errs %0d %h/%0d expected errs %0d 0000/0", err_cnt0, digits0, count0, e0); end
    press0(13'h1 << KEY_BKSP);
    checks++; if (err_cnt0 !== e0 + 1) begin errors++; $display("FAIL bksp_empty_err: got %0d expected %0d", err_cnt0, e0 + 1); end
    press0(13'h1 << KEY_CLR);
    checks++; if (err_cnt0 !== e0 + 1 || count0 !== 3'd0) begin errors++; $display("FAIL clr_empty: got errs %0d cnt %0d expected %0d/0", err_cnt0, count0, e0 + 1); end
  endtask

  task automatic test_same_cycle();
    int e0;
    press0(kd(1));
    e0 = err_cnt0;
    press0(kd(2) | kd(5));
    checks++; if (err_cnt0 !== e0 + 1 || digits0 !== 16'h0001 || count0 !== 3'd1) begin errors++; $display("FAIL two_digits: got errs %0d %h/%0d expected %0d 0001/1", err_cnt0, digits0, count0, e0 + 1); end
    press0((13'h1 << KEY_CLR) | kd(3));
    checks++; if (err_cnt0 !== e0 + 1 || digits0 !== 16'h0 || count0 !== 3'd0) begin errors++; $display("FAIL clr_with_digit: got errs %0d %h/%0d expected %0d 0000/0", err_cnt0, digits0, count0, e0 + 1); end
    press0(13'h1 << KEY_ENTER);
    checks++; if (err_cnt0 !== e0 + 2 || state0 !== ST_ENTRY) begin errors++; $display("FAIL enter_empty: got errs %0d st %0d expected %0d st 0", err_cnt0, state0, e0 + 2); end
    press0(kd(2));
    press0((13'h1 << KEY_BKSP) | kd(6));
    checks++; if (digits0 !== 16'h0 || count0 !== 3'd0) begin errors++; $display("FAIL bksp_over_digit: got %h/%0d expected 0000/0", digits0, count0); end
  endtask

  task automatic test_debounce();
    int e1;
    e1 = err_cnt1;
    pb1[6] = 1'b1; repeat (2) @(posedge clk); #1;
    pb1[6] = 1'b0; repeat (2) @(posedge clk); #1;
    pb1[6] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (count1 !== 3'd0) begin errors++; $display("FAIL debounce_early: got %0d expected 0", count1); end
    @(posedge clk); #1;
    checks++; if (count1 !== 3'd1 || digits1 !== 16'h0006) begin errors++; $display("FAIL debounce_press: got %h/%0d expected 0006/1", digits1, count1); end
    repeat (3) @(posedge clk); #1;
    pb1[6] = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (count1 !== 3'd1 || err_cnt1 !== e1) begin errors++; $display("FAIL debounce_release: got cnt %0d errs %0d expected 1/%0d", count1, err_cnt1, e1); end
    pb1[5] = 1'b1; repeat (3) @(posedge clk); #1;
    pb1[5] = 1'b0;
    repeat (12) @(posedge clk); #1;
    checks++; if (count1 !== 3'd1 || digits1 !== 16'h0006) begin errors++; $display("FAIL debounce_glitch: got %h/%0d expected 0006/1", digits1, count1); end
  endtask

  task automatic test_reset_convert();
    press0(kd(5)); press0(kd(6));
    enter0 = 1'b1;
    @(posedge clk); #1;
    enter0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state0 !== ST_CONVERT) begin errors++; $display("FAIL pre_reset_state: got %0d expected %0d", state0, ST_CONVERT); end
    rst_n = 1'b0;
    #1;
    checks++; if (digits0 !== 16'h0 || count0 !== 3'd0 || state0 !== ST_ENTRY) begin errors++; $display("FAIL async_reset_entry: got %h/%0d st %0d expected 0000/0 st 0", digits0, count0, state0); end
    checks++; if (res0.value !== 14'd0 || res0.value_valid !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL async_reset_value: got %0d/%b/%b expected 0/0/0", res0.value, res0.value_valid, err0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    press0(kd(4));
    press0(13'h1 << KEY_ENTER);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (res0.value !== 14'd4 || res0.value_valid !== 1'b1) begin errors++; $display("FAIL post_reset_value: got %0d/%b expected 4/1", res0.value, res0.value_valid); end
    accept0();
  endtask

  initial begin
    checks = 0; errors = 0; err_cnt0 = 0; err_cnt1 = 0;
    rst_n = 1'b0;
    pb0 = '0; clr0 = 1'b0; bksp0 = 1'b0; enter0 = 1'b0;
    pb1 = '0; clr1 = 1'b0; bksp1 = 1'b0; enter1 = 1'b0;
    res0.value_ready = 1'b0;
    res1.value_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_entry_convert();
    test_overflow();
    test_backspace();
    test_same_cycle();
    test_debounce();
    test_reset_convert();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
